// File: rtl/controle_lote.sv
// controle_lote
// Batch sequencer for the bottling line. Picks a bottle from the reservoir,
// carries it under the valve, fills it, waits for the QC verdict and then
// either counts it (units/dozens) or pulses the discard gate. Every wait on
// an external input is guarded by a watchdog. Once LOTE_DUZIAS dozens are
// approved the batch is flagged complete.
//
// Ports
//   CLK            system clock, rising edge
//   reset          synchronous, active-low reset
//   start          one-cycle pulse: start / restart a batch (IDLE, FIM, FALHA)
//   repor          one-cycle pulse: one bottle added to the reservoir
//   garrafa        bottle present under the valve
//   cheia          bottle full
//   aprovado       QC verdict: approved
//   reprovado      QC verdict: rejected (wins over aprovado)
//   motor          conveyor motor command
//   valvula        fill valve command
//   descartado     discard gate, one-cycle pulse
//   alarme         arrival/fill watchdog expired
//   alarmeEstoque  reservoir empty while a bottle is needed
//   loteOk         batch complete
//   unidades       approved bottles in the current dozen (0..11)
//   duzias         completed dozens (0..LOTE_DUZIAS)
//   estoque        reservoir count (saturates at CAP_ESTOQUE)
module controle_lote #(
  parameter int unsigned LOTE_DUZIAS = 2,
  parameter int unsigned T_CHEGADA   = 100,
  parameter int unsigned T_ENCHE     = 50,
  parameter int unsigned T_CQ        = 20,
  parameter int unsigned CAP_ESTOQUE = 15
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  input  logic       repor,
  input  logic       garrafa,
  input  logic       cheia,
  input  logic       aprovado,
  input  logic       reprovado,
  output logic       motor,
  output logic       valvula,
  output logic       descartado,
  output logic       alarme,
  output logic       alarmeEstoque,
  output logic       loteOk,
  output logic [3:0] unidades,
  output logic [3:0] duzias,
  output logic [3:0] estoque
);

  typedef enum logic [3:0] {
    IDLE,
    PEGA,
    TRANSPORTE,
    ENCHE,
    CQ,
    DESCARTE,
    CONTA,
    FIM,
    FALHA,
    SEM_ESTOQUE
  } state_t;

  // Watchdog compares happen against T-1 so the state is left exactly T
  // cycles after entry (the counter reads 0 on the first edge in a state).
  localparam logic [7:0] LIM_CHEGADA = 8'(T_CHEGADA - 1);
  localparam logic [7:0] LIM_ENCHE   = 8'(T_ENCHE - 1);
  localparam logic [7:0] LIM_CQ      = 8'(T_CQ - 1);
  localparam logic [3:0] LOTE        = 4'(LOTE_DUZIAS);
  localparam logic [3:0] CAP         = 4'(CAP_ESTOQUE);

  state_t     state, stateNext;
  logic [7:0] espera;
  logic [3:0] unidadesNext, duziasNext, estoqueNext;
  logic       retira;

  // Next-state and batch counter logic. The awaited input is tested before
  // the watchdog limit so an input arriving on the last allowed cycle wins.
  always_comb begin
    stateNext    = state;
    unidadesNext = unidades;
    duziasNext   = duzias;
    retira       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          unidadesNext = 4'd0;
          duziasNext   = 4'd0;
          stateNext    = PEGA;
        end
      end
      PEGA: begin
        if (estoque == 4'd0) begin
          stateNext = SEM_ESTOQUE;
        end else begin
          retira    = 1'b1;
          stateNext = TRANSPORTE;
        end
      end
      TRANSPORTE: begin
        if (garrafa) stateNext = ENCHE;
        else if (espera == LIM_CHEGADA) stateNext = FALHA;
      end
      ENCHE: begin
        if (cheia) stateNext = CQ;
        else if (espera == LIM_ENCHE) stateNext = FALHA;
      end
      CQ: begin
        if (reprovado) stateNext = DESCARTE;
        else if (aprovado) stateNext = CONTA;
        else if (espera == LIM_CQ) stateNext = DESCARTE;
      end
      DESCARTE: stateNext = PEGA;
      CONTA: begin
        if (unidades == 4'd11) begin
          unidadesNext = 4'd0;
          duziasNext   = duzias + 4'd1;
          stateNext    = (duziasNext == LOTE) ? FIM : PEGA;
        end else begin
          unidadesNext = unidades + 4'd1;
          stateNext    = PEGA;
        end
      end
      FIM: begin
        if (start) begin
          unidadesNext = 4'd0;
          duziasNext   = 4'd0;
          stateNext    = PEGA;
        end
      end
      // The timed-out bottle is simply lost; counters are kept.
      FALHA: begin
        if (start) stateNext = PEGA;
      end
      SEM_ESTOQUE: begin
        if (repor) stateNext = PEGA;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Reservoir arithmetic: a refill coinciding with a pick cancels out,
  // otherwise refills saturate at the capacity.
  always_comb begin
    estoqueNext = estoque;
    if (repor && retira) estoqueNext = estoque;
    else if (repor && (estoque < CAP)) estoqueNext = estoque + 4'd1;
    else if (retira) estoqueNext = estoque - 4'd1;
  end

  // Watchdog cycle counter, cleared whenever the state changes and held at
  // its maximum in states that never consult it.
  always_ff @(posedge CLK) begin
    if (!reset) espera <= 8'd0;
    else if (stateNext != state) espera <= 8'd0;
    else if (espera != 8'hFF) espera <= espera + 8'd1;
  end

  // State register plus registered Moore outputs decoded from the next
  // state, so each output settles on the same edge the state is entered.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state         <= IDLE;
      unidades      <= 4'd0;
      duzias        <= 4'd0;
      estoque       <= 4'd0;
      motor         <= 1'b0;
      valvula       <= 1'b0;
      descartado    <= 1'b0;
      alarme        <= 1'b0;
      alarmeEstoque <= 1'b0;
      loteOk        <= 1'b0;
    end else begin
      state         <= stateNext;
      unidades      <= unidadesNext;
      duzias        <= duziasNext;
      estoque       <= estoqueNext;
      motor         <= (stateNext == TRANSPORTE);
      valvula       <= (stateNext == ENCHE);
      descartado    <= (stateNext == DESCARTE);
      alarme        <= (stateNext == FALHA);
      alarmeEstoque <= (stateNext == SEM_ESTOQUE);
      loteOk        <= (stateNext == FIM);
    end
  end

endmodule

// File: tb/tb_controle_lote.sv
// Testbench for controle_lote (built with LOTE_DUZIAS=1, other defaults).
// Bottles are described by a table of records; each one is driven through
// the line, its expected outcome is pushed onto a scoreboard queue, and the
// entry is popped and compared when the DUT shows the count or discard.
module tb_controle_lote;

  localparam int LOTE      = 1;
  localparam int T_CHEGADA = 100;
  localparam int T_CQ      = 20;
  localparam int CAP       = 15;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       repor = 1'b0;
  logic       garrafa = 1'b0;
  logic       cheia = 1'b0;
  logic       aprovado = 1'b0;
  logic       reprovado = 1'b0;
  logic       motor, valvula, descartado, alarme, alarmeEstoque, loteOk;
  logic [3:0] unidades, duzias, estoque;

  typedef struct {
    int         gDelay;
    int         cDelay;
    logic [1:0] verdict;
    int         vDelay;
    bit         discard;
  } vec_t;

  typedef struct {
    bit         discard;
    logic [3:0] unid;
    logic [3:0] duz;
    bit         lote;
  } exp_t;

  exp_t sb[$];
  vec_t tab[7];

  int nChecks = 0;
  int nErrors = 0;
  int overlapCnt = 0;
  int expUnid = 0;
  int expDuz = 0;
  int expEst = 0;

  controle_lote #(
    .LOTE_DUZIAS(LOTE),
    .T_CHEGADA(T_CHEGADA),
    .T_ENCHE(50),
    .T_CQ(T_CQ),
    .CAP_ESTOQUE(CAP)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .start(start),
    .repor(repor),
    .garrafa(garrafa),
    .cheia(cheia),
    .aprovado(aprovado),
    .reprovado(reprovado),
    .motor(motor),
    .valvula(valvula),
    .descartado(descartado),
    .alarme(alarme),
    .alarmeEstoque(alarmeEstoque),
    .loteOk(loteOk),
    .unidades(unidades),
    .duzias(duzias),
    .estoque(estoque)
  );

  always #5 CLK = ~CLK;

  // Motor and valve must never be commanded together.
  always @(negedge CLK) begin
    if (motor === 1'b1 && valvula === 1'b1) overlapCnt++;
  end

  // Hard stop in case the whole run wedges.
  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // sel 0: motor high, 1: valve high, 2: valve low
  task automatic waitSig(input int sel, input string name);
    int  n;
    bit  hit;
    n = 0;
    hit = 0;
    while (!hit && n < 300) begin
      @(negedge CLK);
      n++;
      case (sel)
        0: hit = (motor === 1'b1);
        1: hit = (valvula === 1'b1);
        default: hit = (valvula === 1'b0);
      endcase
    end
    checkOutput(name, 32'(hit), 32'd1);
  endtask

  task automatic pulseRepor();
    repor = 1'b1;
    @(negedge CLK);
    repor = 1'b0;
    if (expEst < CAP) expEst++;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    expUnid = 0;
    expDuz = 0;
    expEst = 0;
  endtask

  // Drives one bottle from TRANSPORTE to its outcome and scores it.
  task automatic applyStimulus(input vec_t v);
    exp_t e, got;
    int   n, prevU, prevD;
    bit   hit;
    waitSig(0, "waitMotor");
    repeat (v.gDelay) @(negedge CLK);
    garrafa = 1'b1;
    waitSig(1, "waitValvula");
    garrafa = 1'b0;
    repeat (v.cDelay) @(negedge CLK);
    cheia = 1'b1;
    waitSig(2, "waitCq");
    cheia = 1'b0;

    prevU = expUnid;
    prevD = expDuz;
    e.discard = v.discard;
    e.lote = 1'b0;
    if (!v.discard) begin
      if (expUnid == 11) begin
        expUnid = 0;
        expDuz++;
        e.lote = (expDuz == LOTE);
      end else begin
        expUnid++;
      end
    end
    e.unid = 4'(expUnid);
    e.duz = 4'(expDuz);
    sb.push_back(e);

    n = 0;
    if (v.verdict != 2'b00) begin
      repeat (v.vDelay) @(negedge CLK);
      aprovado = v.verdict[0];
      reprovado = v.verdict[1];
      @(negedge CLK);
      aprovado = 1'b0;
      reprovado = 1'b0;
      n = v.vDelay + 1;
    end

    hit = 0;
    while (!hit && n < 80) begin
      if (descartado === 1'b1 || unidades !== 4'(prevU) || duzias !== 4'(prevD)) hit = 1;
      else begin
        @(negedge CLK);
        n++;
      end
    end

    got = sb.pop_front();
    checkOutput("outcomeSeen", 32'(hit), 32'd1);
    checkOutput("descartado", 32'(descartado), 32'(got.discard));
    checkOutput("unidades", 32'(unidades), 32'(got.unid));
    checkOutput("duzias", 32'(duzias), 32'(got.duz));
    checkOutput("loteOk", 32'(loteOk), 32'(got.lote));
    if (v.verdict == 2'b00) checkOutput("cqTimeoutCycles", 32'(n), 32'(T_CQ));
    if (got.discard) begin
      @(negedge CLK);
      checkOutput("discardPulseWidth", 32'(descartado), 32'd0);
    end
    if (!got.lote && expEst > 0) expEst--;
  endtask

  initial begin
    int   cnt;
    vec_t v;

    // gDelay, cDelay, verdict {reprovado,aprovado}, vDelay, expected discard
    tab[0] = '{0, 0, 2'b01, 0, 1'b0};
    tab[1] = '{2, 3, 2'b01, 1, 1'b0};
    tab[2] = '{5, 1, 2'b01, 4, 1'b0};
    tab[3] = '{1, 2, 2'b11, 0, 1'b1};
    tab[4] = '{0, 1, 2'b00, 0, 1'b1};
    tab[5] = '{3, 0, 2'b01, 19, 1'b0};
    tab[6] = '{1, 1, 2'b10, 2, 1'b1};

    // Reset state
    @(negedge CLK);
    doReset();
    checkOutput("rstMotor", 32'(motor), 32'd0);
    checkOutput("rstValvula", 32'(valvula), 32'd0);
    checkOutput("rstDescartado", 32'(descartado), 32'd0);
    checkOutput("rstAlarme", 32'(alarme), 32'd0);
    checkOutput("rstAlarmeEstoque", 32'(alarmeEstoque), 32'd0);
    checkOutput("rstLoteOk", 32'(loteOk), 32'd0);
    checkOutput("rstUnidades", 32'(unidades), 32'd0);
    checkOutput("rstDuzias", 32'(duzias), 32'd0);
    checkOutput("rstEstoque", 32'(estoque), 32'd0);

    // Three bottles, all approved, until the reservoir runs dry
    repeat (3) pulseRepor();
    checkOutput("estoqueAfterRefill3", 32'(estoque), 32'(expEst));
    pulseStart();
    expEst--;
    for (int i = 0; i < 3; i++) applyStimulus(tab[i]);
    @(negedge CLK);
    checkOutput("semEstoqueAlarm", 32'(alarmeEstoque), 32'd1);
    checkOutput("estoqueEmpty", 32'(estoque), 32'd0);
    checkOutput("unidadesThree", 32'(unidades), 32'd3);

    // Refill from SEM_ESTOQUE: alarm clears, motor two cycles later
    pulseRepor();
    checkOutput("semEstoqueCleared", 32'(alarmeEstoque), 32'd0);
    checkOutput("estoqueRefilled", 32'(estoque), 32'd1);
    @(negedge CLK);
    expEst--;
    checkOutput("motorAfterRefill", 32'(motor), 32'd1);
    checkOutput("estoqueBackToZero", 32'(estoque), 32'(expEst));

    // More stock while transporting; a stray start must be ignored
    repeat (4) pulseRepor();
    checkOutput("estoqueAfterRefill4", 32'(estoque), 32'(expEst));
    pulseStart();
    checkOutput("startIgnored", 32'(unidades), 32'(expUnid));
    for (int i = 3; i < 7; i++) applyStimulus(tab[i]);

    // Arrival timeout: alarm exactly T_CHEGADA cycles after entry
    waitSig(0, "waitMotorTimeout");
    cnt = 0;
    pulseRepor();
    cnt++;
    pulseRepor();
    cnt++;
    while (alarme !== 1'b1 && cnt < 150) begin
      @(negedge CLK);
      cnt++;
    end
    checkOutput("arrivalTimeoutCycles", 32'(cnt), 32'(T_CHEGADA));
    checkOutput("falhaMotorOff", 32'(motor), 32'd0);
    pulseStart();
    checkOutput("alarmeCleared", 32'(alarme), 32'd0);
    @(negedge CLK);
    expEst--;
    checkOutput("resumeMotor", 32'(motor), 32'd1);
    checkOutput("resumeEstoque", 32'(estoque), 32'(expEst));
    checkOutput("falhaKeepsUnidades", 32'(unidades), 32'(expUnid));

    // Full batch of one dozen
    doReset();
    repeat (20) begin
      if (expEst < 15) pulseRepor();
    end
    checkOutput("estoqueFull", 32'(estoque), 32'd15);
    pulseStart();
    expEst--;
    for (int i = 0; i < 12; i++) begin
      v = '{i % 3, i % 2, 2'b01, i % 4, 1'b0};
      applyStimulus(v);
    end
    checkOutput("loteDone", 32'(loteOk), 32'd1);
    checkOutput("loteEstoque", 32'(estoque), 32'd3);
    @(negedge CLK);
    checkOutput("loteHold", 32'(loteOk), 32'd1);
    checkOutput("loteMotorOff", 32'(motor), 32'd0);

    // New batch from FIM, then reset in the middle of a fill
    pulseStart();
    expUnid = 0;
    expDuz = 0;
    checkOutput("newBatchLoteOk", 32'(loteOk), 32'd0);
    checkOutput("newBatchDuzias", 32'(duzias), 32'd0);
    waitSig(0, "waitMotorFill");
    checkOutput("newBatchEstoque", 32'(estoque), 32'd2);
    garrafa = 1'b1;
    waitSig(1, "waitValvulaFill");
    garrafa = 1'b0;
    checkOutput("fillingValvula", 32'(valvula), 32'd1);
    doReset();
    checkOutput("resetValvula", 32'(valvula), 32'd0);
    checkOutput("resetUnidades", 32'(unidades), 32'd0);
    checkOutput("resetDuzias", 32'(duzias), 32'd0);
    checkOutput("resetEstoque", 32'(estoque), 32'd0);
    garrafa = 1'b1;
    cheia = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("idleMotor", 32'(motor), 32'd0);
    checkOutput("idleValvula", 32'(valvula), 32'd0);
    checkOutput("idleAlarmeEstoque", 32'(alarmeEstoque), 32'd0);
    garrafa = 1'b0;
    cheia = 1'b0;
    repeat (20) pulseRepor();
    checkOutput("estoqueSaturates", 32'(estoque), 32'd15);

    checkOutput("motorValvulaExclusive", 32'(overlapCnt), 32'd0);
    checkOutput("scoreboardEmpty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/controle_lote.md
# controle_lote

Batch sequencer for the bottling line. It drives the conveyor motor and the fill valve, waits for the quality-check verdict, and commands the discard gate. It also tracks the bottle reservoir and counts approved bottles in units and dozens until a batch of `LOTE_DUZIAS` dozens is complete. It sits above the fill FSM and the QC stage as the single owner of motor, valve and discard, and adds watchdog timeouts on every wait.

## Interface
Parameters:
- `LOTE_DUZIAS`, default 2: dozens per batch, range 1..15.
- `T_CHEGADA`, default 100: maximum cycles in TRANSPORTE waiting for `garrafa`.
- `T_ENCHE`, default 50: maximum cycles in ENCHE waiting for `cheia`.
- `T_CQ`, default 20: maximum cycles in CQ waiting for a verdict.
- `CAP_ESTOQUE`, default 15: reservoir capacity, 4-bit counter.

Ports:
- `CLK`  in  1  single system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle pulse, already debounced and edge-detected upstream.
- `repor`  in  1  single-cycle pulse; adds one bottle to the reservoir.
- `garrafa`  in  1  level; bottle present under the valve.
- `cheia`  in  1  level; bottle full.
- `aprovado`, `reprovado`  in  1 each  level; QC verdict.
- `motor`, `valvula`, `descartado`  out  1 each  actuator commands.
- `alarme`  out  1  watchdog timeout on arrival or fill.
- `alarmeEstoque`  out  1  reservoir empty while a bottle is needed.
- `loteOk`  out  1  batch complete.
- `unidades`  out  4  approved bottles in the current dozen, 0..11.
- `duzias`  out  4  completed dozens, 0..`LOTE_DUZIAS`.
- `estoque`  out  4  reservoir count.

## Operation
- States: IDLE, PEGA, TRANSPORTE, ENCHE, CQ, DESCARTE, CONTA, FIM, FALHA, SEM_ESTOQUE.
- IDLE: on `start`, clear `unidades` and `duzias`, then go to PEGA.
- PEGA:
  - If `estoque`==0, go to SEM_ESTOQUE.
  - Otherwise decrement `estoque` and go to TRANSPORTE.
- TRANSPORTE (`motor`=1):
  - `garrafa`=1: go to ENCHE.
  - No bottle after `T_CHEGADA` cycles: go to FALHA.
- ENCHE (`valvula`=1, `motor`=0):
  - `cheia`=1: go to CQ.
  - Not full after `T_ENCHE` cycles: go to FALHA.
- CQ (all actuators 0):
  - `reprovado`=1: go to DESCARTE. If both verdicts are asserted in the same cycle, `reprovado` wins.
  - `aprovado`=1 alone: go to CONTA.
  - No verdict after `T_CQ` cycles: go to DESCARTE.
- DESCARTE: `descartado`=1 for exactly one cycle, then go to PEGA.
- CONTA:
  - If `unidades`==11: set `unidades` to 0 and increment `duzias`. If the new `duzias`==`LOTE_DUZIAS`, go to FIM; otherwise go to PEGA.
  - Otherwise increment `unidades` and go to PEGA.
- FIM: `loteOk`=1. Counters hold their values until `start`, which starts a new batch: clear counters, go to PEGA.
- FALHA: `alarme`=1 and all actuators 0. Counters hold. `start` clears `alarme` and resumes at PEGA; the bottle that timed out is lost and not refunded to the reservoir.
- SEM_ESTOQUE: `alarmeEstoque`=1, actuators 0. The next `repor` increments `estoque`, clears the alarm and returns to PEGA in the same edge.
- `repor` in any state: `estoque` += 1, saturating at `CAP_ESTOQUE`.
- `repor` in the same cycle as the PEGA decrement: the net change to `estoque` is 0.
- `start` in any state other than IDLE, FIM and FALHA is ignored.

## Timing
- All outputs are registered Moore outputs and are valid one cycle after the state is entered.
- Input response: an input sampled at edge k changes state at edge k; the corresponding output changes after edge k.
- Watchdog:
  - An 8-bit cycle counter clears on every state entry.
  - A timeout fires at the edge where the counter equals T-1 and the awaited input is still 0. State is left exactly T cycles after entry.
  - If the awaited input arrives on that same cycle, the input wins over the timeout.
- Nominal cycle for one approved bottle: PEGA 1 + TRANSPORTE ≥1 + ENCHE ≥1 + CQ ≥1 + CONTA 1, so at least 5 cycles.
- Reset (`reset`=0 at an edge):
  - State goes to IDLE.
  - `motor`, `valvula`, `descartado`, `alarme`, `alarmeEstoque` and `loteOk` go to 0.
  - `unidades`, `duzias` and `estoque` go to 0.
  - Reset overrides every other input in that cycle, including mid-fill: `valvula` drops on the next edge.

## Test plan
- Reset, 3× `repor`, `start`, then 3 bottles each with `garrafa`, `cheia`, `aprovado` → `estoque`=0, `unidades`=3, and `motor`/`valvula` never high in the same cycle.
- `LOTE_DUZIAS`=1, `CAP_ESTOQUE`=15, refill 15, run 12 approved bottles → `duzias`=1, `unidades`=0, `loteOk`=1 after the 12th CONTA, `estoque`=3.
- `aprovado` and `reprovado` asserted in the same cycle in CQ → `descartado` pulses for 1 cycle and `unidades` is unchanged; a separate case with no verdict for `T_CQ`=20 cycles → discard at cycle 20.
- `garrafa` held low in TRANSPORTE → `alarme`=1 exactly `T_CHEGADA` cycles after entry; `start` → `alarme`=0 and the line resumes at PEGA with `estoque` one lower.
- Reservoir empty with `start` → `alarmeEstoque`=1; `repor` → alarm clears, `motor`=1 two cycles later, `estoque` returns to 0.
- `reset` low during ENCHE with `valvula`=1 → `valvula`=0 on the next edge, all counters 0, state IDLE; 20× `repor` → `estoque` saturates at 15.
